// File: rtl/weight_update.sv
// rtl/weight_update.sv - per-layer weight/bias update stage (delta x activation gradient step)
module weight_update #(
    parameter int NC = 4,
    parameter int NP = 4,
    parameter int WD = 8,
    parameter int WA = 8,
    parameter int WW = 12,
    parameter int LR = 8,
    parameter int FA = 7
) (
    input  logic                        iCLK,
    input  logic                        iRST,
    input  logic                        iValid_AS,
    output logic                        oReady_AS,
    input  logic [NC*WD+NP*WA-1:0]      iData_AS,
    output logic                        oValid_BS,
    input  logic                        iReady_BS,
    output logic [NC*NP*WW+NC*WW-1:0]   oData_BS
);

    localparam int IW = NC*WD + NP*WA;
    // Product of signed delta and zero-extended activation.
    localparam int PW = WD + WA + 1;
    // Subtraction width: one bit wider than either operand so it never wraps.
    localparam int SW = ((WW > PW) ? WW : PW) + 1;
    localparam int CW = (NP > 1) ? $clog2(NP) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(NP - 1);
    localparam logic signed [SW-1:0] SAT_MAX = SW'((2**(WW-1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2**(WW-1)));

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_BIAS,
        S_OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic [IW-1:0]          in_q;
    logic [CW-1:0]          col;
    logic signed [WW-1:0]   w_q [NC][NP];
    logic signed [WW-1:0]   b_q [NC];

    logic signed [WD-1:0]   delta [NC];
    logic [WA-1:0]          act [NP];
    logic [WA-1:0]          act_sel;
    logic signed [WW-1:0]   w_new [NC];
    logic signed [WW-1:0]   b_new [NC];
    logic                   accept;

    function automatic logic signed [WW-1:0] sat_ww(input logic signed [SW-1:0] x);
        if (x > SAT_MAX) begin
            return WW'(SAT_MAX);
        end else if (x < SAT_MIN) begin
            return WW'(SAT_MIN);
        end
        return WW'(x);
    endfunction

    function automatic logic signed [WW-1:0] weight_step(
        input logic signed [WW-1:0] w_old,
        input logic signed [WD-1:0] d,
        input logic [WA-1:0]        a
    );
        logic signed [PW-1:0] d_ext;
        logic signed [PW-1:0] a_ext;
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] g;
        logic signed [SW-1:0] diff;
        d_ext = PW'(d);
        a_ext = PW'($signed({1'b0, a}));
        prod  = d_ext * a_ext;
        g     = prod >>> LR;
        diff  = SW'(w_old) - SW'(g);
        return sat_ww(diff);
    endfunction

    function automatic logic signed [WW-1:0] bias_step(
        input logic signed [WW-1:0] b_old,
        input logic signed [WD-1:0] d
    );
        logic signed [WD-1:0] g;
        logic signed [SW-1:0] diff;
        g    = d >>> (LR - FA);
        diff = SW'(b_old) - SW'(g);
        return sat_ww(diff);
    endfunction

    // Unpack the captured packet and compute the candidate column and bias updates.
    always_comb begin
        for (int c = 0; c < NC; c++) begin
            delta[c] = in_q[c*WD +: WD];
        end
        for (int p = 0; p < NP; p++) begin
            act[p] = in_q[NC*WD + p*WA +: WA];
        end
        act_sel = act[col];
        for (int c = 0; c < NC; c++) begin
            w_new[c] = weight_step(w_q[c][col], delta[c], act_sel);
            b_new[c] = bias_step(b_q[c], delta[c]);
        end
    end

    // Handshake outputs and next-state selection.
    always_comb begin
        state_next = state;
        oReady_AS  = 1'b0;
        oValid_BS  = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                oReady_AS = ~iRST;
                accept    = iValid_AS & ~iRST;
                if (accept) begin
                    state_next = S_ACC;
                end
            end
            S_ACC: begin
                if (col == COL_LAST) begin
                    state_next = S_BIAS;
                end
            end
            S_BIAS: begin
                state_next = S_OUT;
            end
            S_OUT: begin
                oValid_BS = 1'b1;
                if (iReady_BS) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Packet capture, column counter and parameter registers.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            in_q <= '0;
            col  <= '0;
            for (int c = 0; c < NC; c++) begin
                b_q[c] <= '0;
                for (int p = 0; p < NP; p++) begin
                    w_q[c][p] <= '0;
                end
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        in_q <= iData_AS;
                        col  <= '0;
                    end
                end
                S_ACC: begin
                    for (int c = 0; c < NC; c++) begin
                        w_q[c][col] <= w_new[c];
                    end
                    if (col != COL_LAST) begin
                        col <= col + 1'b1;
                    end
                end
                S_BIAS: begin
                    for (int c = 0; c < NC; c++) begin
                        b_q[c] <= b_new[c];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Parameter registers drive the output bus directly.
    always_comb begin
        oData_BS = '0;
        for (int c = 0; c < NC; c++) begin
            for (int p = 0; p < NP; p++) begin
                oData_BS[(c*NP + p)*WW +: WW] = w_q[c][p];
            end
            oData_BS[NC*NP*WW + c*WW +: WW] = b_q[c];
        end
    end

endmodule

// File: tb/tb_weight_update.sv
// tb/tb_weight_update.sv - self-checking bench for weight_update
module tb_weight_update;

    localparam int NC = 2;
    localparam int NP = 3;
    localparam int WD = 8;
    localparam int WA = 8;
    localparam int WW = 12;
    localparam int LR = 8;
    localparam int FA = 7;
    localparam int IW = NC*WD + NP*WA;
    localparam int OW = NC*NP*WW + NC*WW;
    localparam int WMAX = 2**(WW-1) - 1;
    localparam int WMIN = -(2**(WW-1));

    logic          iCLK = 1'b0;
    logic          iRST;
    logic          iValid_AS;
    logic          oReady_AS;
    logic [IW-1:0] iData_AS;
    logic          oValid_BS;
    logic          iReady_BS;
    logic [OW-1:0] oData_BS;

    int n_checks = 0;
    int n_fail   = 0;

    int pd [NC];
    int pa [NP];
    int mw [NC][NP];
    int mb [NC];

    weight_update #(
        .NC(NC), .NP(NP), .WD(WD), .WA(WA), .WW(WW), .LR(LR), .FA(FA)
    ) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iValid_AS (iValid_AS),
        .oReady_AS (oReady_AS),
        .iData_AS  (iData_AS),
        .oValid_BS (oValid_BS),
        .iReady_BS (iReady_BS),
        .oData_BS  (oData_BS)
    );

    always #5 iCLK = ~iCLK;

    function automatic int floor_div(input int x, input int k);
        if (x >= 0) return x / k;
        return -((-x + k - 1) / k);
    endfunction

    function automatic int clamp(input int x);
        if (x > WMAX) return WMAX;
        if (x < WMIN) return WMIN;
        return x;
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < NC; c++) begin
            mb[c] = 0;
            for (int p = 0; p < NP; p++) mw[c][p] = 0;
        end
    endfunction

    function automatic void model_apply();
        for (int c = 0; c < NC; c++) begin
            for (int p = 0; p < NP; p++)
                mw[c][p] = clamp(mw[c][p] - floor_div(pd[c] * pa[p], 2**LR));
            mb[c] = clamp(mb[c] - floor_div(pd[c], 2**(LR-FA)));
        end
    endfunction

    function automatic logic [OW-1:0] model_pack();
        logic [OW-1:0] e;
        e = '0;
        for (int c = 0; c < NC; c++) begin
            for (int p = 0; p < NP; p++) e[(c*NP + p)*WW +: WW] = WW'(mw[c][p]);
            e[NC*NP*WW + c*WW +: WW] = WW'(mb[c]);
        end
        return e;
    endfunction

    function automatic logic [IW-1:0] pack_in();
        logic [IW-1:0] v;
        v = '0;
        for (int c = 0; c < NC; c++) v[c*WD +: WD] = WD'(pd[c]);
        for (int p = 0; p < NP; p++) v[NC*WD + p*WA +: WA] = WA'(pa[p]);
        return v;
    endfunction

    function automatic void random_packet();
        for (int c = 0; c < NC; c++) pd[c] = int'($urandom_range(0, 255)) - 128;
        for (int p = 0; p < NP; p++) pa[p] = int'($urandom_range(0, 255));
    endfunction

    task automatic do_reset();
        iRST = 1'b1;
        iValid_AS = 1'b0;
        iReady_BS = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;
        iRST = 1'b0;
        model_clear();
    endtask

    // Called 1 time unit after an edge while idle; returns edges from accept to valid.
    task automatic run_packet(output int lat);
        iData_AS  = pack_in();
        iValid_AS = 1'b1;
        @(posedge iCLK);
        #1;
        iValid_AS = 1'b0;
        iData_AS  = IW'({$urandom, $urandom});
        lat = 0;
        while (!oValid_BS && lat < 50) begin
            @(posedge iCLK);
            #1;
            lat++;
        end
        model_apply();
    endtask

    task automatic release_out();
        iReady_BS = 1'b1;
        @(posedge iCLK);
        #1;
        iReady_BS = 1'b0;
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        iValid_AS = 1'b0;
        iReady_BS = 1'b0;
        iData_AS = '0;
        repeat (3) @(posedge iCLK);
        #1;
        n_checks++;
        if (oReady_AS !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_forced: got %b want 0", oReady_AS);
        end
        iRST = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (oReady_AS !== 1'b1 || oValid_BS !== 1'b0 || oData_BS !== '0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b valid=%b data=%h want 1/0/0", oReady_AS, oValid_BS, oData_BS);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge iCLK);
            #1;
            n_checks++;
            if (oReady_AS !== 1'b1 || oValid_BS !== 1'b0 || oData_BS !== '0) begin
                n_fail++;
                $display("FAIL reset_idle_%0d: ready=%b valid=%b data=%h want 1/0/0", i, oReady_AS, oValid_BS, oData_BS);
            end
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [OW-1:0] exp_v;
        pd[0] = 16;  pd[1] = -16;
        pa[0] = 128; pa[1] = 64; pa[2] = 0;
        run_packet(lat);
        n_checks++;
        if (lat !== NP + 1) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges want %0d", lat, NP + 1);
        end
        // w0 = {-8,-4,0}, w1 = {8,4,0}, b0 = -8, b1 = 8
        exp_v = {12'sd8, -12'sd8, 12'sd0, 12'sd4, 12'sd8, 12'sd0, -12'sd4, -12'sd8};
        n_checks++;
        if (oData_BS !== exp_v) begin
            n_fail++;
            $display("FAIL basic_data: got %h want %h", oData_BS, exp_v);
        end
        n_checks++;
        if (oData_BS !== model_pack()) begin
            n_fail++;
            $display("FAIL basic_model: got %h want %h", oData_BS, model_pack());
        end
        release_out();
    endtask

    task automatic test_rounding();
        int lat;
        do_reset();
        pd[0] = -1; pd[1] = 0;
        for (int p = 0; p < NP; p++) pa[p] = 1;
        run_packet(lat);
        for (int p = 0; p < NP; p++) begin
            n_checks++;
            if ($signed(oData_BS[p*WW +: WW]) !== 12'sd1) begin
                n_fail++;
                $display("FAIL round_w0%0d: got %0d want 1", p, $signed(oData_BS[p*WW +: WW]));
            end
        end
        n_checks++;
        if ($signed(oData_BS[NC*NP*WW +: WW]) !== 12'sd1) begin
            n_fail++;
            $display("FAIL round_b0: got %0d want 1", $signed(oData_BS[NC*NP*WW +: WW]));
        end
        release_out();
    endtask

    task automatic test_saturation();
        int lat;
        do_reset();
        pd[0] = -128; pd[1] = 0;
        pa[0] = 255;  pa[1] = 0; pa[2] = 0;
        for (int k = 1; k <= 16; k++) begin
            run_packet(lat);
            if (k == 15) begin
                n_checks++;
                if ($signed(oData_BS[0 +: WW]) !== 12'sd1920) begin
                    n_fail++;
                    $display("FAIL sat_w00_15: got %0d want 1920", $signed(oData_BS[0 +: WW]));
                end
            end
            if (k == 16) begin
                n_checks++;
                if ($signed(oData_BS[0 +: WW]) !== 12'sd2047) begin
                    n_fail++;
                    $display("FAIL sat_w00_16: got %0d want 2047", $signed(oData_BS[0 +: WW]));
                end
                n_checks++;
                if (oData_BS !== model_pack()) begin
                    n_fail++;
                    $display("FAIL sat_model: got %h want %h", oData_BS, model_pack());
                end
            end
            release_out();
        end
    endtask

    task automatic test_random();
        int lat;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            random_packet();
            run_packet(lat);
            n_checks++;
            if (lat !== NP + 1 || oData_BS !== model_pack()) begin
                n_fail++;
                $display("FAIL random_%0d: lat=%0d data=%h want lat=%0d data=%h", k, lat, oData_BS, NP + 1, model_pack());
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [OW-1:0] exp_v;
        random_packet();
        run_packet(lat);
        exp_v = model_pack();
        for (int i = 0; i < 10; i++) begin
            iValid_AS = i[0];
            iData_AS  = IW'({$urandom, $urandom});
            @(posedge iCLK);
            #1;
            n_checks++;
            if (oValid_BS !== 1'b1 || oReady_AS !== 1'b0 || oData_BS !== exp_v) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: valid=%b ready=%b data=%h want 1/0/%h", i, oValid_BS, oReady_AS, oData_BS, exp_v);
            end
        end
        iValid_AS = 1'b0;
        release_out();
        n_checks++;
        if (oValid_BS !== 1'b0 || oReady_AS !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b ready=%b want 0/1", oValid_BS, oReady_AS);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge iCLK);
            #1;
            n_checks++;
            if (oValid_BS !== 1'b0 || oReady_AS !== 1'b1 || oData_BS !== exp_v) begin
                n_fail++;
                $display("FAIL bp_no_take_%0d: valid=%b ready=%b data=%h want 0/1/%h", i, oValid_BS, oReady_AS, oData_BS, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        random_packet();
        iData_AS  = pack_in();
        iValid_AS = 1'b1;
        @(posedge iCLK);
        #1;
        iValid_AS = 1'b0;
        @(posedge iCLK);
        #1;
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        n_checks++;
        if (oValid_BS !== 1'b0 || oReady_AS !== 1'b0 || oData_BS !== '0) begin
            n_fail++;
            $display("FAIL midrst_state: valid=%b ready=%b data=%h want 0/0/0", oValid_BS, oReady_AS, oData_BS);
        end
        iRST = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (oReady_AS !== 1'b1 || oValid_BS !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: ready=%b valid=%b want 1/0", oReady_AS, oValid_BS);
        end
        @(posedge iCLK);
        #1;
        test_basic();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
